// File: rtl/scan_seq_pkg.sv
// Shared types for the scan sequencer: FSM states, walk direction, index width helper.
package scan_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Width of an index into WIDTH channels; a single channel still needs one bit.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mask_next_idx.sv
// Combinational search for the nearest set mask bit beyond cur_i in direction dir_i.
// incl_i also accepts cur_i itself, which turns the search into "lowest set bit" for start.
module mask_next_idx
    import scan_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] mask_i,
    input  logic [IDX_W-1:0] cur_i,
    input  dir_e             dir_i,
    input  logic             incl_i,
    output logic [IDX_W-1:0] nxt_o,
    output logic             at_end_o
);

    always_comb begin
        nxt_o    = cur_i;
        at_end_o = 1'b1;
        if (dir_i == DIR_UP) begin
            // Descending scan so the last hit is the closest bit above cur_i.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (mask_i[i] && ((i > int'(cur_i)) || (incl_i && (i == int'(cur_i))))) begin
                    nxt_o    = IDX_W'(i);
                    at_end_o = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mask_i[i] && ((i < int'(cur_i)) || (incl_i && (i == int'(cur_i))))) begin
                    nxt_o    = IDX_W'(i);
                    at_end_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Walks a masked channel set (sweep or ping-pong, single-shot or continuous), holding each
// index for D cycles and driving a one-hot decoder; all outputs registered, 1-cycle start latency.
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16,
    parameter int IDX_W   = idx_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               pingpong,
    input  logic               continuous,
    output logic [IDX_W-1:0]   idx,
    output logic               en,
    output logic               step,
    output logic               done
);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   low_q, low_d;
    logic               en_q, en_d;
    logic               step_q, step_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] reload_q, reload_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic               pp_q, pp_d;
    logic               cont_q, cont_d;

    logic               pass_end;
    dir_e               rev_dir;
    logic [IDX_W-1:0]   start_idx;
    logic               start_none;
    logic [IDX_W-1:0]   fwd_idx;
    logic               fwd_end;
    logic [IDX_W-1:0]   rev_idx;
    logic               rev_end;
    logic [DWELL_W-1:0] dwell_reload;

    assign rev_dir      = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
    assign dwell_reload = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

    // Lowest set bit of the live mask, only consumed when a start is accepted.
    mask_next_idx #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_low (
        .mask_i   (mask),
        .cur_i    ('0),
        .dir_i    (DIR_UP),
        .incl_i   (1'b1),
        .nxt_o    (start_idx),
        .at_end_o (start_none)
    );

    mask_next_idx #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_fwd (
        .mask_i   (mask_q),
        .cur_i    (idx_q),
        .dir_i    (dir_q),
        .incl_i   (1'b0),
        .nxt_o    (fwd_idx),
        .at_end_o (fwd_end)
    );

    mask_next_idx #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_rev (
        .mask_i   (mask_q),
        .cur_i    (idx_q),
        .dir_i    (rev_dir),
        .incl_i   (1'b0),
        .nxt_o    (rev_idx),
        .at_end_o (rev_end)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        idx_d    = idx_q;
        low_d    = low_q;
        en_d     = en_q;
        step_d   = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        mask_d   = mask_q;
        pp_d     = pp_q;
        cont_d   = cont_q;
        pass_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && !start_none) begin
                    state_d  = ST_RUN;
                    mask_d   = mask;
                    reload_d = dwell_reload;
                    cnt_d    = dwell_reload;
                    pp_d     = pingpong;
                    cont_d   = continuous;
                    idx_d    = start_idx;
                    low_d    = start_idx;
                    dir_d    = DIR_UP;
                    en_d     = 1'b1;
                    step_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d  = reload_q;
                    step_d = 1'b1;
                    if (!fwd_end) begin
                        idx_d = fwd_idx;
                    end else if (!pp_q) begin
                        if (cont_q) idx_d = low_q;
                        else        pass_end = 1'b1;
                    end else if (rev_end) begin
                        // Single channel in ping-pong: hold it, one dwell per pass.
                        if (!cont_q) pass_end = 1'b1;
                    end else if (dir_q == DIR_DOWN) begin
                        if (cont_q) begin
                            idx_d = rev_idx;
                            dir_d = DIR_UP;
                        end else begin
                            pass_end = 1'b1;
                        end
                    end else begin
                        idx_d = rev_idx;
                        dir_d = DIR_DOWN;
                    end

                    if (pass_end) begin
                        state_d = ST_IDLE;
                        en_d    = 1'b0;
                        step_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_UP;
            idx_q    <= '0;
            low_q    <= '0;
            en_q     <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            reload_q <= '0;
            mask_q   <= '0;
            pp_q     <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            idx_q    <= idx_d;
            low_q    <= low_d;
            en_q     <= en_d;
            step_q   <= step_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            mask_q   <= mask_d;
            pp_q     <= pp_d;
            cont_q   <= cont_d;
        end
    end

    assign idx  = idx_q;
    assign en   = en_q;
    assign step = step_q;
    assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: an 8-channel and a 5-channel instance share one clock.
module tb_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start5;
    logic        stop;
    logic [7:0]  mask;
    logic [4:0]  mask5;
    logic [15:0] dwell;
    logic        pingpong;
    logic        continuous;

    logic [2:0]  idx;
    logic        en, step, done;
    logic [2:0]  idx5;
    logic        en5, step5, done5;

    int tests;
    int fails;

    scan_sequencer #(.WIDTH(8), .DWELL_W(16)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .dwell      (dwell),
        .pingpong   (pingpong),
        .continuous (continuous),
        .idx        (idx),
        .en         (en),
        .step       (step),
        .done       (done)
    );

    scan_sequencer #(.WIDTH(5), .DWELL_W(16)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .start      (start5),
        .stop       (stop),
        .mask       (mask5),
        .dwell      (dwell),
        .pingpong   (pingpong),
        .continuous (continuous),
        .idx        (idx5),
        .en         (en5),
        .step       (step5),
        .done       (done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_idx, input logic e_en,
                             input logic e_step, input logic e_done);
        check({tag, ".idx"},  {29'd0, idx},  {29'd0, e_idx});
        check({tag, ".en"},   {31'd0, en},   {31'd0, e_en});
        check({tag, ".step"}, {31'd0, step}, {31'd0, e_step});
        check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    logic [2:0] seq_cont [0:9];
    logic [2:0] seq_pp   [0:9];

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        start5     = 1'b0;
        stop       = 1'b0;
        mask       = 8'h00;
        mask5      = 5'h00;
        dwell      = 16'd1;
        pingpong   = 1'b0;
        continuous = 1'b0;
        seq_cont   = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7, 3'd2};
        seq_pp     = '{3'd0, 3'd0, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd0, 3'd0};

        #2;
        check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        check("reset.en5", {31'd0, en5}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_out("idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Full mask, dwell 1, single-shot sweep.
        mask = 8'hFF; dwell = 16'd1; pingpong = 1'b0; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_out($sformatf("sweep1.c%0d", k), 3'(k), 1'b1, 1'b1, 1'b0);
            tick();
        end
        check_out("sweep1.done", 3'd7, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("sweep1.after", 3'd7, 1'b0, 1'b0, 1'b0);

        // Continuous sweep over 2,5,7 with dwell 3; mask changed mid-run, then stop.
        mask = 8'b1010_0100; dwell = 16'd3; continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        mask  = 8'h01;
        for (int k = 0; k < 10; k++) begin
            check_out($sformatf("cont.c%0d", k), seq_cont[k], 1'b1, (k % 3) == 0, 1'b0);
            tick();
        end
        start = 1'b1;
        check_out("cont.c10", 3'd2, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check_out("cont.stop", 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("cont.stop2", 3'd2, 1'b0, 1'b0, 1'b0);

        // Ping-pong single-shot over 0,3,4 with dwell 2.
        mask = 8'b0001_1001; dwell = 16'd2; pingpong = 1'b1; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_out($sformatf("pp.c%0d", k), seq_pp[k], 1'b1, (k % 2) == 0, 1'b0);
            tick();
        end
        check_out("pp.done", 3'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Dwell 0 acts as 1.
        mask = 8'b0000_0110; dwell = 16'd0; pingpong = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("dw0.c0", 3'd1, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("dw0.c1", 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("dw0.done", 3'd2, 1'b0, 1'b0, 1'b1);
        tick();

        // Empty mask start is ignored.
        mask = 8'h00; dwell = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("mask0.c0", 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("mask0.c1", 3'd2, 1'b0, 1'b0, 1'b0);

        // start and stop together in IDLE: stop wins.
        mask = 8'hFF;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_out("startstop", 3'd2, 1'b0, 1'b0, 1'b0);

        // 5-channel instance, single top channel, ping-pong single-shot, dwell 3.
        mask5 = 5'b1_0000; dwell = 16'd3; pingpong = 1'b1; continuous = 1'b0;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("w5.c%0d.idx", k),  {29'd0, idx5}, 32'd4);
            check($sformatf("w5.c%0d.en", k),   {31'd0, en5},  32'd1);
            check($sformatf("w5.c%0d.step", k), {31'd0, step5}, (k == 0) ? 32'd1 : 32'd0);
            check($sformatf("w5.c%0d.done", k), {31'd0, done5}, 32'd0);
            tick();
        end
        check("w5.done.en",   {31'd0, en5},   32'd0);
        check("w5.done.done", {31'd0, done5}, 32'd1);
        check("w5.done.idx",  {29'd0, idx5},  32'd4);
        check("w5.dut8.en",   {31'd0, en},    32'd0);
        tick();

        // Reset in the middle of a continuous scan, then a clean restart.
        mask = 8'b0011_1000; dwell = 16'd4; pingpong = 1'b0; continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_out("prerst", 3'd3, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_out("rst.async", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        mask = 8'b0100_0000; dwell = 16'd1; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("rst.restart", 3'd6, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("rst.done", 3'd6, 1'b0, 1'b0, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Generates the index/enable stream that drives the one-hot `decoder` (`WIDTH` outputs). It walks a masked set of channels, holding each index for a programmable number of clock cycles. Two walk patterns are supported: upward sweep with wrap, and ping-pong. Each walk can be single-shot or continuous. The block sits directly upstream of `decoder`: `idx` connects to `decoder.in` and `en` connects to `decoder.enable`.

## Interface
- `WIDTH`, 8, number of decoder outputs/channels; `IDX_W = $clog2(WIDTH)`
- `DWELL_W`, 16, width of dwell count

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a scan; honoured only in IDLE
- `stop`  in  1  abort the scan; returns to IDLE without `done`
- `mask`  in  WIDTH  channel enable mask; bit i=1 → channel i visited; sampled at accepted `start`
- `dwell`  in  DWELL_W  cycles per index; 0 treated as 1; sampled at accepted `start`
- `pingpong`  in  1  0 = upward sweep, 1 = up/down ping-pong; sampled at accepted `start`
- `continuous`  in  1  0 = one pass then stop, 1 = repeat until `stop`; sampled at accepted `start`
- `idx`  out  IDX_W  current channel index, registered
- `en`  out  1  index valid / decoder enable, registered
- `step`  out  1  one-cycle pulse in the first cycle of each dwell period
- `done`  out  1  one-cycle pulse when a single-shot pass completes

## Operation
- States: IDLE, RUN. Reset → IDLE. Reset values: `idx`=0, `en`=0, `step`=0, `done`=0.
- **IDLE**
  - `start`=1, `stop`=0, `mask`≠0 → capture `mask`, D=max(`dwell`,1), mode bits.
  - Then go to RUN with `idx` = lowest set mask bit (L), direction up, dwell counter = D-1.
  - `start` with `mask`=0 is ignored.
  - `start`∧`stop` in IDLE: `stop` wins.
- **RUN**
  - `en`=1. The counter decrements each cycle.
  - At count 0, advance to the next set bit of the captured mask in the current direction, and reload the counter to D-1.
- **Sweep mode**
  - Order is ascending. After the highest set bit (H), the pass ends.
  - Continuous: next index = L.
  - Single-shot: go to IDLE, `en`=0, `done`=1 for that cycle; `idx` holds its last value.
- **Ping-pong mode**
  - Order is L..H, then H-1..L (the endpoints are not repeated). The direction flips at H and at L.
  - One pass = from L up to H and back to the end of L's dwell.
  - Continuous: the next index after L is the next set bit above L.
  - Single-shot: end as in sweep mode.
  - If only one channel is set: hold it. The pass ends after one dwell.
- **Stop and start while running**
  - `stop` in RUN → IDLE next edge: `en`=0, `done`=0, `step`=0.
  - `start` in RUN is ignored.
- **Mid-run input changes:** `mask`, `dwell`, `pingpong` and `continuous` have no effect until the next accepted `start`.
- **Index range:** `idx` never exceeds WIDTH-1. Non-power-of-two `WIDTH` must be handled.
- **Reset mid-scan:** immediate return to reset values.

## Timing
- `start` sampled at edge t → `en`=1, `idx`=L, `step`=1 in cycle t+1.
- Each index is held exactly D cycles.
- `step` is high in the first cycle of every dwell period, including the first.
- Single-shot with N visits: `en` high for N·D cycles. `done` is high in the first cycle with `en`=0.
  - Ping-pong with k set bits (k≥2): N = 2k-1.
- `stop` at edge s → `en`=0 from cycle s+1.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package/header `scan_seq_pkg`:
  - State encodings IDLE/RUN.
  - Direction encodings UP/DOWN.
  - Helper for IDX_W.
- Sub-module `mask_next_idx` (combinational):
  - Inputs: mask, current index, direction.
  - Outputs: next set index, plus flag `at_end` when no set bit lies beyond the current index in that direction.
  - Also used to find L at start.
- Top level holds the FSM, the dwell counter, and the captured configuration registers.

## Test plan
- WIDTH=8, mask=8'hFF, dwell=1, sweep, single-shot:
  - `idx` = 0..7 on consecutive cycles, `step` high all 8 cycles.
  - `en` high 8 cycles; `done` pulses in cycle 9 with `en`=0.
- mask=8'b1010_0100, dwell=3, sweep, continuous:
  - `idx` sequence 2,2,2,5,5,5,7,7,7,2…
  - `stop` mid-dwell → `en`=0 next cycle, no `done`.
- mask=8'b0001_1001, dwell=2, ping-pong, single-shot:
  - `idx` = 0,0,3,3,4,4,3,3,0,0, then `done` pulses.
- Edge cases:
  - dwell=0 behaves as 1.
  - mask=0 with `start` → stays IDLE, `en` stays 0.
  - `start`∧`stop` together in IDLE → no run.
  - Changing `mask` during RUN does not alter the sequence.
- WIDTH=5, mask=5'b1_0000, ping-pong, single-shot: `idx`=4 for D cycles, then `done`.
- Assert `rst` mid-scan:
  - All outputs return to 0 asynchronously.
  - A subsequent `start` begins cleanly at L.
